// File: rtl/serial_tx_frame.sv
// UART-style frame serialiser: start bit, DATA_BITS data, optional parity, 1-2 stop bits.
// Start bit appears on the edge that accepts start; a new start is taken only when idle or in the done cycle.
module serial_tx_frame #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int MSB_FIRST    = 1
) (
  input  logic                 baud_clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 bit_out_tx,
  output logic                 busy,
  output logic                 serial_end,
  output logic                 done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  generate
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
      $error("serial_tx_frame: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("serial_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 1) begin : g_bad_cpb
      $error("serial_tx_frame: CLKS_PER_BIT must be at least 1");
    end
    if (DATA_BITS < 5 || DATA_BITS > 16) begin : g_bad_width
      $error("serial_tx_frame: DATA_BITS must be in 5..16");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cyc_q, cyc_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;

  logic                 bit_end;
  logic                 last_cycle;
  logic                 accept;
  logic                 next_bit;
  logic [DATA_BITS-1:0] shifted;

  assign bit_end    = (cyc_q == CYC_LAST);
  assign last_cycle = (state_q == STOP) && (bit_q == STOP_LAST) && bit_end;
  assign accept     = start && ((state_q == IDLE) || last_cycle);

  // The outgoing data bit is always taken from the shift register's leading end.
  assign next_bit = (MSB_FIRST != 0) ? shreg_q[DATA_BITS-1] : shreg_q[0];
  assign shifted  = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);

  always_ff @(posedge baud_clk) begin
    if (reset) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;

    if (state_q != IDLE) begin
      cyc_d = bit_end ? '0 : cyc_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = next_bit;
          shreg_d = shifted;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY_MODE != 0) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = next_bit;
            shreg_d = shifted;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
          bit_d   = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
          tx_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Acceptance overrides the end-of-frame return to IDLE, giving gapless back-to-back frames.
    if (accept) begin
      state_d = START;
      tx_d    = 1'b0;
      shreg_d = data_in;
      par_d   = (PARITY_MODE == 2) ? ~(^data_in) : ^data_in;
      cyc_d   = '0;
      bit_d   = '0;
    end
  end

  assign bit_out_tx = tx_q;
  assign busy       = (state_q != IDLE);
  assign serial_end = (state_q == IDLE);
  assign done       = last_cycle;

endmodule

// File: tb/tb_serial_tx_frame.sv
// Three differently-configured serialisers driven by directed and random requests; a frame-level
// reference model queues the expected per-cycle line/done values and a monitor compares each cycle.
module tb_serial_tx_frame;

  logic       baud_clk = 1'b0;
  logic       reset;
  logic [2:0] start;
  logic [7:0] din [3];
  logic [2:0] tx, busy, send, done;
  logic       mon_en = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 baud_clk = ~baud_clk;

  int cfg_cpb [3] = '{1, 1, 4};
  int cfg_pm  [3] = '{1, 2, 0};
  int cfg_sb  [3] = '{1, 2, 1};
  int cfg_msb [3] = '{1, 0, 1};

  serial_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(1), .PARITY_MODE(1), .STOP_BITS(1), .MSB_FIRST(1)) dut0 (
    .baud_clk(baud_clk), .reset(reset), .start(start[0]), .data_in(din[0]),
    .bit_out_tx(tx[0]), .busy(busy[0]), .serial_end(send[0]), .done(done[0]));

  serial_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(1), .PARITY_MODE(2), .STOP_BITS(2), .MSB_FIRST(0)) dut1 (
    .baud_clk(baud_clk), .reset(reset), .start(start[1]), .data_in(din[1]),
    .bit_out_tx(tx[1]), .busy(busy[1]), .serial_end(send[1]), .done(done[1]));

  serial_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(1), .MSB_FIRST(1)) dut2 (
    .baud_clk(baud_clk), .reset(reset), .start(start[2]), .data_in(din[2]),
    .bit_out_tx(tx[2]), .busy(busy[2]), .serial_end(send[2]), .done(done[2]));

  typedef struct packed {
    logic line;
    logic done;
  } exp_t;

  exp_t exp_q [3][$];

  // Builds the whole frame as a list of line levels, then stretches each to CLKS_PER_BIT cycles.
  function automatic void push_frame(int i, logic [7:0] d);
    logic bits [$];
    exp_t e;
    bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) begin
      bits.push_back(cfg_msb[i] != 0 ? d[7-k] : d[k]);
    end
    if (cfg_pm[i] != 0) begin
      bits.push_back((^d) ^ (cfg_pm[i] == 2));
    end
    for (int k = 0; k < cfg_sb[i]; k++) begin
      bits.push_back(1'b1);
    end
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < cfg_cpb[i]; c++) begin
        e.line = bits[b];
        e.done = (b == bits.size() - 1) && (c == cfg_cpb[i] - 1);
        exp_q[i].push_back(e);
      end
    end
  endfunction

  // Queue empty at an edge means the cycle just ended was idle or the final frame cycle.
  always @(posedge baud_clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset === 1'b1) begin
        exp_q[i].delete();
      end else if (start[i] === 1'b1 && exp_q[i].size() == 0) begin
        push_frame(i, din[i]);
      end
    end
  end

  always @(negedge baud_clk) begin
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        exp_t e;
        logic eb;
        if (exp_q[i].size() > 0) begin
          e  = exp_q[i].pop_front();
          eb = 1'b1;
        end else begin
          e.line = 1'b1;
          e.done = 1'b0;
          eb     = 1'b0;
        end
        vectors++;
        if (tx[i] !== e.line || busy[i] !== eb || send[i] !== ~eb || done[i] !== e.done) begin
          miscompares++;
          $display("FAIL cycle_dut%0d t=%0t line/busy/serial_end/done got %b%b%b%b want %b%b%b%b",
                   i, $time, tx[i], busy[i], send[i], done[i], e.line, eb, ~eb, e.done);
        end
      end
    end
  end

  task automatic tick();
    @(posedge baud_clk);
    #1;
  endtask

  task automatic send_one(int i, logic [7:0] d, int wait_cycles);
    start[i] = 1'b1;
    din[i]   = d;
    tick();
    start[i] = 1'b0;
    repeat (wait_cycles) tick();
  endtask

  initial begin
    reset = 1'b1;
    start = '0;
    for (int i = 0; i < 3; i++) din[i] = 8'h00;
    tick();
    mon_en = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    send_one(0, 8'hA5, 12);
    send_one(1, 8'h01, 13);
    send_one(2, 8'hFF, 42);

    // Back-to-back: start held across the done cycle of the first frame.
    start[0] = 1'b1;
    din[0]   = 8'h3C;
    tick();
    din[0] = 8'hC3;
    repeat (11) tick();
    start[0] = 1'b0;
    din[0]   = 8'h77;
    repeat (12) tick();

    // Requests and data changes while busy must be ignored.
    send_one(0, 8'h5A, 3);
    start[0] = 1'b1;
    din[0]   = 8'h00;
    tick();
    start[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      din[0] = ~din[0];
      tick();
    end

    // Reset during cycle 5 of a frame, then a fresh frame two cycles later.
    send_one(0, 8'h96, 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    send_one(0, 8'h5A, 12);

    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 3; i++) begin
        start[i] = ($urandom_range(0, 3) == 0);
        din[i]   = 8'($urandom);
      end
      reset = ($urandom_range(0, 149) == 0);
      tick();
    end
    start = '0;
    reset = 1'b0;
    repeat (60) tick();

    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (exp_q[i].size() != 0) begin
        miscompares++;
        $display("FAIL drain_dut%0d pending expected cycles got %0d want 0", i, exp_q[i].size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
